// File: rtl/matrix_mult_stream_engine_if.sv
// Operand/result streaming bundle for the matrix multiply engine.
// The engine sits on the slave side: it consumes rdata and produces wdata.
// The master side is the operand reader / result writer pair around it.
interface matrix_mult_stream_engine_if #(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int OW    = 18
);
   logic [LANES*WIDTH-1:0] rdata;
   logic                   read_en;
   logic                   read_ready;
   logic [LANES*OW-1:0]    wdata;
   logic                   write_ready;
   logic                   write_en;

   modport slave (
      input  rdata,
      input  read_en,
      input  write_en,
      output read_ready,
      output wdata,
      output write_ready
   );

   modport master (
      output rdata,
      output read_en,
      output write_en,
      input  read_ready,
      input  wdata,
      input  write_ready
   );
endinterface

// File: rtl/matrix_mult_stream_engine.sv
// N x N integer matrix multiplier, C = A*B or C = C + A*B.
// A and B arrive LANES elements per beat, row-major. One C element is produced
// per cycle from N parallel products summed in a tree, then C streams out
// LANES elements per beat under backpressure.
module matrix_mult_stream_engine #(
   parameter int WIDTH  = 8,
   parameter int N      = 4,
   parameter int LANES  = 4,
   parameter int SIGNED = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic acc_mode,
   output logic busy,
   output logic done,
   matrix_mult_stream_engine_if.slave bus
);

   localparam int OW    = 2*WIDTH + $clog2(N);
   localparam int NN    = N*N;
   localparam int BEATS = NN / LANES;
   localparam int IW    = $clog2(NN);
   localparam int CW    = IW + 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      COMPUTE,
      OUT
   } state_t;

   state_t          stateQ;
   logic [CW-1:0]   beatQ;
   logic [CW-1:0]   rowQ;
   logic [CW-1:0]   colQ;
   logic            accQ;
   logic            readReadyQ;
   logic            writeReadyQ;
   logic            busyQ;
   logic            doneQ;

   logic [WIDTH-1:0] aQ [NN];
   logic [WIDTH-1:0] bQ [NN];
   logic [OW-1:0]    cQ [NN];

   logic             readFire;
   logic             writeFire;
   logic             lastBeat;
   logic             lastElem;
   logic [IW-1:0]    elemIdx;

   logic [WIDTH-1:0]   aEl;
   logic [WIDTH-1:0]   bEl;
   logic [2*WIDTH-1:0] prod;
   logic [OW-1:0]      prodX;
   logic [OW-1:0]      dotD;
   logic [OW-1:0]      cNextD;
   logic [LANES*OW-1:0] wdataD;

   assign readFire  = bus.read_en & readReadyQ;
   assign writeFire = bus.write_en & writeReadyQ;
   assign lastBeat  = (beatQ == CW'(BEATS-1));
   assign lastElem  = (rowQ == CW'(N-1)) && (colQ == CW'(N-1));
   assign elemIdx   = IW'(int'(rowQ)*N + int'(colQ));

   // Dot product of row rowQ of A with column colQ of B, plus the held C element when accumulating
   always_comb begin
      dotD  = '0;
      aEl   = '0;
      bEl   = '0;
      prod  = '0;
      prodX = '0;
      for (int k = 0; k < N; k++) begin
         aEl = aQ[IW'(int'(rowQ)*N + k)];
         bEl = bQ[IW'(k*N + int'(colQ))];
         if (SIGNED != 0) begin
            prod  = $signed({{WIDTH{aEl[WIDTH-1]}}, aEl}) * $signed({{WIDTH{bEl[WIDTH-1]}}, bEl});
            prodX = {{(OW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
         end else begin
            prod  = {{WIDTH{1'b0}}, aEl} * {{WIDTH{1'b0}}, bEl};
            prodX = {{(OW-2*WIDTH){1'b0}}, prod};
         end
         dotD = dotD + prodX;
      end
      cNextD = dotD + (accQ ? cQ[elemIdx] : '0);
   end

   // Operand and result storage; deliberately not reset so C survives for accumulate jobs
   always_ff @(posedge clk) begin
      if (readFire) begin
         for (int l = 0; l < LANES; l++) begin
            if (stateQ == LOAD_A) begin
               aQ[IW'(int'(beatQ)*LANES + l)] <= bus.rdata[l*WIDTH +: WIDTH];
            end else begin
               bQ[IW'(int'(beatQ)*LANES + l)] <= bus.rdata[l*WIDTH +: WIDTH];
            end
         end
      end
      if (stateQ == COMPUTE) begin
         cQ[elemIdx] <= cNextD;
      end
   end

   // Job sequencer with registered handshake and status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ      <= IDLE;
         beatQ       <= '0;
         rowQ        <= '0;
         colQ        <= '0;
         accQ        <= 1'b0;
         readReadyQ  <= 1'b0;
         writeReadyQ <= 1'b0;
         busyQ       <= 1'b0;
         doneQ       <= 1'b0;
      end else begin
         doneQ <= 1'b0;
         case (stateQ)
            IDLE: begin
               if (start) begin
                  accQ       <= acc_mode;
                  beatQ      <= '0;
                  readReadyQ <= 1'b1;
                  busyQ      <= 1'b1;
                  stateQ     <= LOAD_A;
               end
            end
            LOAD_A: begin
               if (readFire) begin
                  if (lastBeat) begin
                     beatQ  <= '0;
                     stateQ <= LOAD_B;
                  end else begin
                     beatQ <= beatQ + 1'b1;
                  end
               end
            end
            LOAD_B: begin
               if (readFire) begin
                  if (lastBeat) begin
                     beatQ      <= '0;
                     rowQ       <= '0;
                     colQ       <= '0;
                     readReadyQ <= 1'b0;
                     stateQ     <= COMPUTE;
                  end else begin
                     beatQ <= beatQ + 1'b1;
                  end
               end
            end
            COMPUTE: begin
               if (lastElem) begin
                  rowQ        <= '0;
                  colQ        <= '0;
                  writeReadyQ <= 1'b1;
                  stateQ      <= OUT;
               end else if (colQ == CW'(N-1)) begin
                  colQ <= '0;
                  rowQ <= rowQ + 1'b1;
               end else begin
                  colQ <= colQ + 1'b1;
               end
            end
            OUT: begin
               if (writeFire) begin
                  if (lastBeat) begin
                     beatQ       <= '0;
                     writeReadyQ <= 1'b0;
                     doneQ       <= 1'b1;
                  end else begin
                     beatQ <= beatQ + 1'b1;
                  end
               end else if (!writeReadyQ) begin
                  busyQ  <= 1'b0;
                  stateQ <= IDLE;
               end
            end
            default: begin
               stateQ <= IDLE;
            end
         endcase
      end
   end

   // Current output beat, forced to zero whenever no beat is being offered
   always_comb begin
      wdataD = '0;
      if (writeReadyQ) begin
         for (int l = 0; l < LANES; l++) begin
            wdataD[l*OW +: OW] = cQ[IW'(int'(beatQ)*LANES + l)];
         end
      end
   end

   assign bus.wdata       = wdataD;
   assign bus.read_ready  = readReadyQ;
   assign bus.write_ready = writeReadyQ;
   assign busy            = busyQ;
   assign done            = doneQ;

endmodule

// File: tb/tb_matrix_mult_stream_engine.sv
// Directed testbench for matrix_mult_stream_engine (WIDTH=8, N=4, LANES=4).
// An unsigned and a signed instance share the same stimulus; each job's
// results are compared beat by beat against hand-derived matrices.
module tb_matrix_mult_stream_engine;

   localparam int WIDTH = 8;
   localparam int N     = 4;
   localparam int LANES = 4;
   localparam int OW    = 18;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        acc_mode;
   logic        read_en;
   logic        write_en;
   logic [31:0] rdata;
   logic        busyU, doneU, busyS, doneS;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   matrix_mult_stream_engine_if #(.WIDTH(WIDTH), .LANES(LANES), .OW(OW)) busU ();
   matrix_mult_stream_engine_if #(.WIDTH(WIDTH), .LANES(LANES), .OW(OW)) busS ();

   assign busU.rdata    = rdata;
   assign busU.read_en  = read_en;
   assign busU.write_en = write_en;
   assign busS.rdata    = rdata;
   assign busS.read_en  = read_en;
   assign busS.write_en = write_en;

   matrix_mult_stream_engine #(.WIDTH(WIDTH), .N(N), .LANES(LANES), .SIGNED(0)) dutU (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .acc_mode (acc_mode),
      .busy     (busyU),
      .done     (doneU),
      .bus      (busU)
   );

   matrix_mult_stream_engine #(.WIDTH(WIDTH), .N(N), .LANES(LANES), .SIGNED(1)) dutS (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .acc_mode (acc_mode),
      .busy     (busyS),
      .done     (doneS),
      .bus      (busS)
   );

   // Single comparison point: counts every vector and reports any miscompare
   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Offer one operand beat and hold it until the engine takes it
   task automatic sendBeat(input logic [31:0] d);
      int t = 0;
      rdata   = d;
      read_en = 1'b1;
      while (!busU.read_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      checkOutput("readReady", busU.read_ready, 1'b1);
      @(posedge clk); #1;
   endtask

   // Pulse start and stream A then B
   task automatic loadOperands(input logic accm, input logic [127:0] aM, input logic [127:0] bM);
      @(negedge clk);
      start    = 1'b1;
      acc_mode = accm;
      @(negedge clk);
      start    = 1'b0;
      acc_mode = 1'b0;
      for (int b = 0; b < 4; b++) sendBeat(aM[b*32 +: 32]);
      for (int b = 0; b < 4; b++) sendBeat(bM[b*32 +: 32]);
      read_en = 1'b0;
   endtask

   // Run a job up to the first offered result beat, optionally with start/read_en noise during COMPUTE
   task automatic applyStimulus(input logic accm, input logic [127:0] aM, input logic [127:0] bM,
                                input bit noise, input string tag);
      int lat;
      loadOperands(accm, aM, bM);
      lat = 1;
      if (noise) begin
         start   = 1'b1;
         read_en = 1'b1;
         rdata   = '1;
      end
      while (!busU.write_ready && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      checkOutput({tag, "_latency"}, lat, 17);
   endtask

   // Drain the result beats, checking data, an optional stall, the done pulse and the return to idle
   task automatic collectOutput(input logic [287:0] expU, input logic [287:0] expS, input bit checkS,
                                input int stallBeat, input string tag);
      int t;
      for (int b = 0; b < 4; b++) begin
         if (b == stallBeat) begin
            write_en = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            checkOutput({tag, "_stallData"}, busU.wdata, expU[b*72 +: 72]);
            checkOutput({tag, "_stallReady"}, busU.write_ready, 1'b1);
         end
         write_en = 1'b1;
         t = 0;
         while (!busU.write_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
         end
         checkOutput({tag, "_writeReady"}, busU.write_ready, 1'b1);
         checkOutput($sformatf("%s_beat%0d", tag, b), busU.wdata, expU[b*72 +: 72]);
         if (checkS) checkOutput($sformatf("%s_signedBeat%0d", tag, b), busS.wdata, expS[b*72 +: 72]);
         @(posedge clk); #1;
      end
      write_en = 1'b0;
      start    = 1'b1;
      checkOutput({tag, "_done"}, doneU, 1'b1);
      checkOutput({tag, "_readyDrop"}, busU.write_ready, 1'b0);
      checkOutput({tag, "_busyInDone"}, busyU, 1'b1);
      @(posedge clk); #1;
      start   = 1'b0;
      read_en = 1'b0;
      checkOutput({tag, "_doneClear"}, doneU, 1'b0);
      checkOutput({tag, "_idle"}, busyU, 1'b0);
      @(posedge clk); #1;
      checkOutput({tag, "_noRestart"}, busyU, 1'b0);
   endtask

   // Hard stop in case something stalls outside the bounded waits
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence of jobs
   initial begin
      logic [127:0] ident, seqM, onesM, m80;
      logic [287:0] expI, expSeq, expMax, expFour, exp64k, expNeg1, expFF, expDiag2;

      for (int e = 0; e < 16; e++) begin
         ident[e*8 +: 8]     = (e/4 == e%4) ? 8'd1 : 8'd0;
         seqM[e*8 +: 8]      = 8'(e);
         onesM[e*8 +: 8]     = 8'hFF;
         m80[e*8 +: 8]       = 8'h80;
         expI[e*18 +: 18]    = (e/4 == e%4) ? 18'd1 : 18'd0;
         expDiag2[e*18 +: 18] = (e/4 == e%4) ? 18'd2 : 18'd0;
         expSeq[e*18 +: 18]  = 18'(e);
         expMax[e*18 +: 18]  = 18'h3F804;
         expFour[e*18 +: 18] = 18'd4;
         exp64k[e*18 +: 18]  = 18'h10000;
         expNeg1[e*18 +: 18] = 18'h3FFFF;
         expFF[e*18 +: 18]   = 18'd255;
      end

      reset    = 1'b0;
      start    = 1'b0;
      acc_mode = 1'b0;
      read_en  = 1'b0;
      write_en = 1'b0;
      rdata    = '0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_busy", busyU, 1'b0);
      checkOutput("rst_done", doneU, 1'b0);
      checkOutput("rst_readReady", busU.read_ready, 1'b0);
      checkOutput("rst_writeReady", busU.write_ready, 1'b0);
      checkOutput("rst_wdata", busU.wdata, 72'h0);
      @(negedge clk);
      reset = 1'b1;

      $display("[TB] identity job with start/read_en noise after loading");
      applyStimulus(1'b0, ident, seqM, 1'b1, "ident");
      read_en = 1'b1;
      rdata   = '1;
      collectOutput(expSeq, expSeq, 1'b0, -1, "ident");

      $display("[TB] unsigned max job with a 3-cycle stall");
      applyStimulus(1'b0, onesM, onesM, 1'b0, "max");
      collectOutput(expMax, expFour, 1'b1, 2, "max");

      $display("[TB] all -128 job");
      applyStimulus(1'b0, m80, m80, 1'b0, "m128");
      collectOutput(exp64k, exp64k, 1'b1, -1, "m128");

      $display("[TB] all -1 times identity job");
      applyStimulus(1'b0, onesM, ident, 1'b0, "neg1");
      collectOutput(expFF, expNeg1, 1'b1, -1, "neg1");

      $display("[TB] accumulate pair");
      applyStimulus(1'b0, ident, ident, 1'b0, "accBase");
      collectOutput(expI, expI, 1'b1, -1, "accBase");
      applyStimulus(1'b1, ident, ident, 1'b0, "accAdd");
      collectOutput(expDiag2, expDiag2, 1'b1, -1, "accAdd");

      $display("[TB] reset in the middle of COMPUTE");
      loadOperands(1'b0, seqM, seqM);
      repeat (5) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("midRst_busy", busyU, 1'b0);
      checkOutput("midRst_busyS", busyS, 1'b0);
      checkOutput("midRst_done", doneU, 1'b0);
      checkOutput("midRst_writeReady", busU.write_ready, 1'b0);
      checkOutput("midRst_wdata", busU.wdata, 72'h0);
      @(negedge clk);
      reset = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("midRst_noDone", doneU, 1'b0);
      checkOutput("midRst_stillIdle", busyU, 1'b0);
      checkOutput("midRst_noOutput", busU.write_ready, 1'b0);

      $display("[TB] fresh job after reset");
      applyStimulus(1'b0, ident, ident, 1'b0, "fresh");
      collectOutput(expI, expI, 1'b1, -1, "fresh");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
